// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared types for the RV32I pipeline stage registers.
//  Revision    : 1.0 - skid-buffer stage state type and order width default
// ============================================================================
package rv32i_types;

    // Number of beats held by a skid stage; encoding doubles as occupancy.
    typedef enum logic [1:0] {
        skid_empty = 2'd0,
        skid_one   = 2'd1,
        skid_two   = 2'd2
    } skid_state_t;

    localparam int ORDER_W_DEFAULT = 64;

endpackage : rv32i_types
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One beat of storage: valid flag, payload and order stamp.
//                Clearing drops only the valid flag so the payload holds.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int WIDTH   = 256,
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [ORDER_W-1:0] i_order,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data,
    output logic [ORDER_W-1:0] o_order
);

    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [ORDER_W-1:0] r_order;

    // Load captures a new beat; clear invalidates it without touching payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_order <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_order <= i_order;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_order = r_order;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Valid/ready pipeline register with a 2-entry skid buffer,
//                synchronous flush and commit-order stamping. All outputs
//                come from registers, so no combinational in->out or
//                out_ready->in_ready path exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
    import rv32i_types::*;
#(
    parameter int WIDTH   = 256,
    parameter int ORDER_W = ORDER_W_DEFAULT,
    parameter int STAMP   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [ORDER_W-1:0] out_order,
    output logic [1:0]         occupancy
);

    skid_state_t        r_state;
    skid_state_t        w_state_nxt;
    logic               r_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_head_load;
    logic               w_head_clear;
    logic               w_head_from_skid;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic [WIDTH-1:0]   w_head_d;
    logic [ORDER_W-1:0] w_head_o;
    logic [ORDER_W-1:0] w_stamp;
    logic               w_head_valid;
    logic               w_skid_valid;
    logic [WIDTH-1:0]   w_skid_data;
    logic [ORDER_W-1:0] w_skid_order;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = w_head_valid & out_ready;

    // State register plus registered ready (low only while the skid is full).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= skid_empty;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != skid_two);
        end
    end

    // Next state and slot controls; flush overrides every transfer.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_load      = 1'b0;
        w_head_clear     = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_state_nxt  = skid_empty;
            w_head_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                skid_empty: begin
                    if (w_in_fire) begin
                        w_state_nxt = skid_one;
                        w_head_load = 1'b1;
                    end
                end
                skid_one: begin
                    if (w_in_fire && w_out_fire) begin
                        w_head_load = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = skid_two;
                        w_skid_load = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt  = skid_empty;
                        w_head_clear = 1'b1;
                    end
                end
                skid_two: begin
                    if (w_out_fire) begin
                        w_state_nxt      = skid_one;
                        w_head_load      = 1'b1;
                        w_head_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = skid_empty;
                    w_head_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    // Order counter advances once per accepted, non-squashed beat.
    generate
        if (STAMP != 0) begin : g_stamp
            logic [ORDER_W-1:0] r_order_cnt;

            // Wraps naturally modulo 2^ORDER_W.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_order_cnt <= '0;
                end else if (w_in_fire && !flush) begin
                    r_order_cnt <= r_order_cnt + ORDER_W'(1);
                end
            end

            assign w_stamp = r_order_cnt;
        end else begin : g_no_stamp
            assign w_stamp = '0;
        end
    endgenerate

    assign w_head_d = w_head_from_skid ? w_skid_data  : in_data;
    assign w_head_o = w_head_from_skid ? w_skid_order : w_stamp;

    pipe_slot #(
        .WIDTH   (WIDTH),
        .ORDER_W (ORDER_W)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_data  (w_head_d),
        .i_order (w_head_o),
        .o_valid (w_head_valid),
        .o_data  (out_data),
        .o_order (out_order)
    );

    pipe_slot #(
        .WIDTH   (WIDTH),
        .ORDER_W (ORDER_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_order (w_stamp),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_order (w_skid_order)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_head_valid;
    // Skid only ever holds a beat behind a valid head: 00, 01 or 10.
    assign occupancy = {w_skid_valid, w_head_valid & ~w_skid_valid};

endmodule : pipe_skid_stage
`default_nettype wire
